// File: rtl/mem_access_unit.sv
// Memory-access unit: MAR/MDR pair plus a word/half/byte load-store engine
// with ready handshake, wait timeout and read-modify-write for sub-word stores.
module mem_access_unit #(
    parameter int unsigned ADDR_W   = 9,
    parameter int unsigned MAX_WAIT = 15
) (
    input  logic              clk,
    input  logic              clr,
    input  logic [31:0]       bus_in,
    input  logic              MARin,
    input  logic              MDRin,
    input  logic              Read,
    input  logic              rd_req,
    input  logic              wr_req,
    input  logic [1:0]        size,
    input  logic              sign_ext,
    input  logic [31:0]       mem_rdata,
    input  logic              mem_ready,
    output logic [31:0]       mdr_out,
    output logic [ADDR_W+1:0] mar_out,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam int unsigned MAR_W = ADDR_W + 2;
    localparam int unsigned CNT_W = (MAX_WAIT > 2) ? $clog2(MAX_WAIT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((MAX_WAIT == 0) ? 0 : MAX_WAIT - 1);

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD_WAIT,
        S_WR_WAIT,
        S_RMW_RD,
        S_RMW_WR
    } state_t;

    state_t             r_state, w_state;
    logic [MAR_W-1:0]   r_mar, w_mar;
    logic [31:0]        r_mdr, w_mdr;
    logic [31:0]        r_wdata, w_wdata;
    logic [CNT_W-1:0]   r_cnt, w_cnt;
    logic [1:0]         r_size, w_size;
    logic               r_sext, w_sext;
    logic               r_en, w_en;
    logic               r_we, w_we;
    logic               r_busy, w_busy;
    logic               r_done, w_done;
    logic               r_err, w_err;
    logic               w_bad;
    logic               w_timeout;

    // Bit offset of the addressed byte or halfword within the word
    function automatic logic [4:0] lane_shift(input logic [1:0] lane, input logic [1:0] sz);
        return (sz == SZ_HALF) ? {lane[1], 4'b0000} : {lane, 3'b000};
    endfunction

    function automatic logic [31:0] extract(input logic [31:0] d, input logic [1:0] lane,
                                            input logic [1:0] sz, input logic sx);
        logic [7:0]  b;
        logic [15:0] h;
        b = 8'(d >> lane_shift(lane, sz));
        h = 16'(d >> lane_shift(lane, sz));
        case (sz)
            SZ_BYTE: return {{24{sx & b[7]}}, b};
            SZ_HALF: return {{16{sx & h[15]}}, h};
            default: return d;
        endcase
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] cur, input logic [31:0] src,
                                          input logic [1:0] lane, input logic [1:0] sz);
        logic [31:0] mask;
        mask = ((sz == SZ_HALF) ? 32'h0000_FFFF : 32'h0000_00FF) << lane_shift(lane, sz);
        return (cur & ~mask) | ((src << lane_shift(lane, sz)) & mask);
    endfunction

    assign w_bad = (size == 2'b11)
                 | ((size == SZ_HALF) & r_mar[0])
                 | ((size == SZ_WORD) & (r_mar[1:0] != 2'b00));
    assign w_timeout = (MAX_WAIT != 0) && (r_cnt == CNT_LAST);

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            r_state <= S_IDLE;
            r_mar   <= '0;
            r_mdr   <= '0;
            r_wdata <= '0;
            r_cnt   <= '0;
            r_size  <= '0;
            r_sext  <= 1'b0;
            r_en    <= 1'b0;
            r_we    <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state;
            r_mar   <= w_mar;
            r_mdr   <= w_mdr;
            r_wdata <= w_wdata;
            r_cnt   <= w_cnt;
            r_size  <= w_size;
            r_sext  <= w_sext;
            r_en    <= w_en;
            r_we    <= w_we;
            r_busy  <= w_busy;
            r_done  <= w_done;
            r_err   <= w_err;
        end
    end

    always_comb begin
        w_state = r_state;
        w_mar   = r_mar;
        w_mdr   = r_mdr;
        w_wdata = r_wdata;
        w_cnt   = r_cnt;
        w_size  = r_size;
        w_sext  = r_sext;
        w_en    = 1'b0;
        w_we    = 1'b0;
        w_busy  = 1'b1;
        w_done  = 1'b0;
        w_err   = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_busy = 1'b0;
                if (rd_req || wr_req) begin
                    w_size = size;
                    w_sext = sign_ext;
                    if (w_bad) begin
                        w_done = 1'b1;
                        w_err  = 1'b1;
                    end else begin
                        w_busy = 1'b1;
                        w_en   = 1'b1;
                        w_cnt  = '0;
                        if (rd_req) begin
                            w_state = S_RD_WAIT;
                        end else if (size == SZ_WORD) begin
                            w_state = S_WR_WAIT;
                            w_we    = 1'b1;
                            w_wdata = r_mdr;
                        end else begin
                            w_state = S_RMW_RD;
                        end
                    end
                end else begin
                    if (MARin) w_mar = bus_in[MAR_W-1:0];
                    if (MDRin) w_mdr = Read ? mem_rdata : bus_in;
                end
            end
            S_RD_WAIT, S_WR_WAIT, S_RMW_RD, S_RMW_WR: begin
                w_en  = 1'b1;
                w_we  = (r_state == S_WR_WAIT) || (r_state == S_RMW_WR);
                w_cnt = r_cnt + CNT_W'(1);
                if (mem_ready) begin
                    w_cnt = '0;
                    if (r_state == S_RMW_RD) begin
                        // Read phase done: merged word becomes the write data
                        w_wdata = merge(mem_rdata, r_mdr, r_mar[1:0], r_size);
                        w_state = S_RMW_WR;
                        w_we    = 1'b1;
                    end else begin
                        if (r_state == S_RD_WAIT)
                            w_mdr = extract(mem_rdata, r_mar[1:0], r_size, r_sext);
                        w_state = S_IDLE;
                        w_en    = 1'b0;
                        w_we    = 1'b0;
                        w_busy  = 1'b0;
                        w_done  = 1'b1;
                    end
                end else if (w_timeout) begin
                    w_state = S_IDLE;
                    w_en    = 1'b0;
                    w_we    = 1'b0;
                    w_busy  = 1'b0;
                    w_done  = 1'b1;
                    w_err   = 1'b1;
                end
            end
            default: begin
                w_state = S_IDLE;
                w_busy  = 1'b0;
            end
        endcase
    end

    assign mdr_out   = r_mdr;
    assign mar_out   = r_mar;
    assign mem_addr  = r_mar[MAR_W-1:2];
    assign mem_wdata = r_wdata;
    assign mem_en    = r_en;
    assign mem_we    = r_we;
    assign busy      = r_busy;
    assign done      = r_done;
    assign err       = r_err;

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit: a memory responder model, a done
// monitor and a write monitor check against queued expectations.
module tb_mem_access_unit;

    localparam int unsigned ADDR_W   = 9;
    localparam int unsigned MAX_WAIT = 4;

    logic              clk;
    logic              clr;
    logic [31:0]       bus_in;
    logic              MARin, MDRin, Read;
    logic              rd_req, wr_req;
    logic [1:0]        size;
    logic              sign_ext;
    logic [31:0]       mem_rdata;
    logic              mem_ready;
    logic [31:0]       mdr_out;
    logic [ADDR_W+1:0] mar_out;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic              mem_en, mem_we, busy, done, err;

    typedef struct {
        logic        err;
        logic [31:0] mdr;
        int          cyc;
    } exp_t;

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [31:0]       data;
    } wr_t;

    exp_t        exp_q[$];
    wr_t         wr_q[$];
    logic [31:0] mem [512];
    int          napp = 0;
    int          nmis = 0;
    int          cyc  = 0;
    int          wait_cycles = 0;
    logic        hang = 1'b0;

    mem_access_unit #(.ADDR_W(ADDR_W), .MAX_WAIT(MAX_WAIT)) dut (
        .clk(clk), .clr(clr), .bus_in(bus_in), .MARin(MARin), .MDRin(MDRin),
        .Read(Read), .rd_req(rd_req), .wr_req(wr_req), .size(size),
        .sign_ext(sign_ext), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
        .mdr_out(mdr_out), .mar_out(mar_out), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_en(mem_en), .mem_we(mem_we),
        .busy(busy), .done(done), .err(err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        napp++;
        if (act !== exp) begin
            nmis++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Memory responder; also acts as the write monitor
    initial begin
        wr_t w;
        int  wc;
        wc = 0;
        mem_ready = 1'b0;
        mem_rdata = '0;
        forever begin
            @(negedge clk);
            if (mem_en && !hang) begin
                mem_rdata = mem[mem_addr];
                mem_ready = (wc >= wait_cycles);
                if (mem_ready) begin
                    wc = 0;
                    if (mem_we) begin
                        napp++;
                        if (wr_q.size() == 0) begin
                            nmis++;
                            $display("FAIL unexpected_write: addr %0d data 0x%08h, none required",
                                     mem_addr, mem_wdata);
                        end else begin
                            w = wr_q.pop_front();
                            if (mem_addr !== w.addr || mem_wdata !== w.data) begin
                                nmis++;
                                $display("FAIL write: got addr %0d data 0x%08h expected addr %0d data 0x%08h",
                                         mem_addr, mem_wdata, w.addr, w.data);
                            end
                        end
                        mem[mem_addr] = mem_wdata;
                    end
                end else begin
                    wc++;
                end
            end else begin
                mem_ready = 1'b0;
                wc = 0;
            end
        end
    end

    // Completion monitor
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (clr && done) begin
                napp++;
                if (exp_q.size() == 0) begin
                    nmis++;
                    $display("FAIL unexpected_done: err %0b mdr 0x%08h at cycle %0d", err, mdr_out, cyc);
                end else begin
                    e = exp_q.pop_front();
                    if (err !== e.err || mdr_out !== e.mdr || cyc != e.cyc) begin
                        nmis++;
                        $display("FAIL done: got err %0b mdr 0x%08h cycle %0d expected err %0b mdr 0x%08h cycle %0d",
                                 err, mdr_out, cyc, e.err, e.mdr, e.cyc);
                    end
                end
            end
        end
    end

    task automatic load_mar(input logic [31:0] v);
        MARin = 1'b1;
        bus_in = v;
        @(negedge clk);
        MARin = 1'b0;
        bus_in = '0;
    endtask

    task automatic load_mdr(input logic [31:0] v);
        MDRin = 1'b1;
        Read = 1'b0;
        bus_in = v;
        @(negedge clk);
        MDRin = 1'b0;
        bus_in = '0;
    endtask

    task automatic issue(input logic rd, input logic wr, input logic [1:0] sz, input logic sx,
                         input logic e_err, input logic [31:0] e_mdr, input int lat);
        exp_q.push_back('{err: e_err, mdr: e_mdr, cyc: cyc + lat});
        rd_req = rd;
        wr_req = wr;
        size = sz;
        sign_ext = sx;
        @(negedge clk);
        rd_req = 1'b0;
        wr_req = 1'b0;
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while (!done && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (!done) begin
            napp++;
            nmis++;
            $display("FAIL done_timeout: no done within 40 cycles, %0d expectations pending", exp_q.size());
            exp_q.delete();
            @(negedge clk);
        end
    endtask

    initial begin
        clr = 1'b0;
        bus_in = '0;
        MARin = 1'b0;
        MDRin = 1'b0;
        Read = 1'b0;
        rd_req = 1'b0;
        wr_req = 1'b0;
        size = 2'b10;
        sign_ext = 1'b0;
        for (int i = 0; i < 512; i++) mem[i] = '0;
        repeat (3) @(negedge clk);
        clr = 1'b1;
        @(negedge clk);

        check("rst_mdr", mdr_out, 32'h0);
        check("rst_mar", 32'(mar_out), 32'h0);
        check("rst_addr", 32'(mem_addr), 32'h0);
        check("rst_wdata", mem_wdata, 32'h0);
        check("rst_en", 32'(mem_en), 32'h0);
        check("rst_we", 32'(mem_we), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_done", 32'(done), 32'h0);
        check("rst_err", 32'(err), 32'h0);

        // Word load, zero wait
        load_mar(32'h010);
        check("mar_load", 32'(mar_out), 32'h010);
        check("mem_addr", 32'(mem_addr), 32'h4);
        mem[4] = 32'hDEAD_BEEF;
        issue(1'b1, 1'b0, 2'b10, 1'b0, 1'b0, 32'hDEAD_BEEF, 2);
        check("load_en", 32'(mem_en), 32'h1);
        wait_done();

        // Byte loads lane 3, signed then unsigned with 2 wait cycles (back-to-back)
        load_mar(32'h013);
        mem[4] = 32'h80FF_1234;
        issue(1'b1, 1'b0, 2'b00, 1'b1, 1'b0, 32'hFFFF_FF80, 2);
        wait_done();
        wait_cycles = 2;
        issue(1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 32'h0000_0080, 4);
        wait_done();
        wait_cycles = 0;

        // Half loads: upper half positive, lower half negative
        load_mar(32'h006);
        mem[1] = 32'h1122_3344;
        issue(1'b1, 1'b0, 2'b01, 1'b1, 1'b0, 32'h0000_1122, 2);
        wait_done();
        load_mar(32'h004);
        mem[1] = 32'h1122_8765;
        issue(1'b1, 1'b0, 2'b01, 1'b1, 1'b0, 32'hFFFF_8765, 2);
        wait_done();

        // Half store via read-modify-write
        load_mar(32'h006);
        load_mdr(32'h0000_ABCD);
        mem[1] = 32'h1122_3344;
        wr_q.push_back('{addr: 9'd1, data: 32'hABCD_3344});
        issue(1'b0, 1'b1, 2'b01, 1'b0, 1'b0, 32'h0000_ABCD, 3);
        wait_done();
        check("mem1_after", mem[1], 32'hABCD_3344);

        // Byte store lane 1 with one wait cycle per phase
        load_mar(32'h011);
        load_mdr(32'h0000_00EE);
        mem[4] = 32'h80FF_1234;
        wait_cycles = 1;
        wr_q.push_back('{addr: 9'd4, data: 32'h80FF_EE34});
        issue(1'b0, 1'b1, 2'b00, 1'b0, 1'b0, 32'h0000_00EE, 5);
        wait_done();
        wait_cycles = 0;

        // Word store
        load_mar(32'h020);
        load_mdr(32'hCAFE_F00D);
        wr_q.push_back('{addr: 9'd8, data: 32'hCAFE_F00D});
        issue(1'b0, 1'b1, 2'b10, 1'b0, 1'b0, 32'hCAFE_F00D, 2);
        wait_done();

        // Check failures: misaligned word, reserved size, misaligned half store
        load_mar(32'h002);
        issue(1'b1, 1'b0, 2'b10, 1'b0, 1'b1, 32'hCAFE_F00D, 1);
        check("misal_en", 32'(mem_en), 32'h0);
        check("misal_busy", 32'(busy), 32'h0);
        wait_done();
        load_mar(32'h010);
        issue(1'b1, 1'b0, 2'b11, 1'b0, 1'b1, 32'hCAFE_F00D, 1);
        check("rsvd_en", 32'(mem_en), 32'h0);
        check("rsvd_busy", 32'(busy), 32'h0);
        wait_done();
        load_mar(32'h005);
        issue(1'b0, 1'b1, 2'b01, 1'b0, 1'b1, 32'hCAFE_F00D, 1);
        check("misal_st_en", 32'(mem_en), 32'h0);
        wait_done();

        // Timeouts: word load, then sub-word store stuck in its read phase
        hang = 1'b1;
        load_mar(32'h010);
        issue(1'b1, 1'b0, 2'b10, 1'b0, 1'b1, 32'hCAFE_F00D, MAX_WAIT + 1);
        wait_done();
        load_mar(32'h011);
        issue(1'b0, 1'b1, 2'b00, 1'b0, 1'b1, 32'hCAFE_F00D, MAX_WAIT + 1);
        wait_done();
        @(negedge clk);
        check("to_en_low", 32'(mem_en), 32'h0);
        hang = 1'b0;

        // Both requests plus a busy-time MAR write
        load_mar(32'h010);
        mem[4] = 32'h1234_5678;
        wait_cycles = 2;
        exp_q.push_back('{err: 1'b0, mdr: 32'h1234_5678, cyc: cyc + 4});
        rd_req = 1'b1;
        wr_req = 1'b1;
        size = 2'b10;
        sign_ext = 1'b0;
        @(negedge clk);
        rd_req = 1'b0;
        wr_req = 1'b0;
        MARin = 1'b1;
        bus_in = 32'h0000_01FC;
        @(negedge clk);
        MARin = 1'b0;
        bus_in = '0;
        wait_done();
        check("mar_hold", 32'(mar_out), 32'h010);
        wait_cycles = 0;

        // Asynchronous reset in the middle of a stalled load
        hang = 1'b1;
        @(negedge clk);
        rd_req = 1'b1;
        size = 2'b10;
        @(negedge clk);
        rd_req = 1'b0;
        @(negedge clk);
        check("pre_rst_en", 32'(mem_en), 32'h1);
        check("pre_rst_busy", 32'(busy), 32'h1);
        clr = 1'b0;
        #1;
        check("arst_mdr", mdr_out, 32'h0);
        check("arst_mar", 32'(mar_out), 32'h0);
        check("arst_en", 32'(mem_en), 32'h0);
        check("arst_busy", 32'(busy), 32'h0);
        check("arst_done", 32'(done), 32'h0);
        check("arst_err", 32'(err), 32'h0);
        @(negedge clk);
        clr = 1'b1;
        hang = 1'b0;
        repeat (8) @(negedge clk);
        check("post_rst_busy", 32'(busy), 32'h0);

        check("exp_q_empty", 32'(exp_q.size()), 32'h0);
        check("wr_q_empty", 32'(wr_q.size()), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", napp, nmis);
        $finish;
    end

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Parametrised memory-access unit replacing the bare MAR/MDR pair between the CPU bus and the RAM. Holds the byte address (MAR) and data (MDR), and runs word, halfword and byte loads and stores through a ready-handshake memory port with variable latency and timeout. Sub-word stores use internal read-modify-write. It sits between BusMuxOut, the bus mux MDR input and the RAM macro.

## Interface
Parameters:
- ADDR_W, 9: word-address width of memory; MAR is ADDR_W+2 bits (byte address).
- MAX_WAIT, 15: maximum cycles waited for mem_ready per memory phase; 0 disables timeout.

Ports:
- clk  in  1  rising-edge clock.
- clr  in  1  asynchronous, active-low reset (0 = reset).
- bus_in  in  32  BusMuxOut.
- MARin  in  1  load MAR from bus_in[ADDR_W+1:0].
- MDRin  in  1  load MDR.
- Read  in  1  with MDRin: 1 = MDR from mem_rdata (legacy direct load), 0 = from bus_in.
- rd_req  in  1  start load (sampled in IDLE only).
- wr_req  in  1  start store (sampled in IDLE only).
- size  in  2  00 byte, 01 half, 10 word, 11 reserved.
- sign_ext  in  1  load: 1 sign-extend, 0 zero-extend.
- mem_rdata  in  32  memory read data.
- mem_ready  in  1  memory accepts/returns current access.
- mdr_out  out  32  MDR contents (bus mux input).
- mar_out  out  ADDR_W+2  MAR contents.
- mem_addr  out  ADDR_W  word address.
- mem_wdata  out  32  store data.
- mem_en  out  1  access request.
- mem_we  out  1  write strobe.
- busy  out  1  FSM not in IDLE.
- done  out  1  one-cycle completion pulse.
- err  out  1  one-cycle pulse with done on misalignment, reserved size or timeout.

## Operation
- All outputs registered. Reset: state IDLE, MAR = 0, MDR = 0, all other outputs 0.
- IDLE: MARin/MDRin act as plain register loads. In any other state, MARin and MDRin are ignored.
- rd_req has priority when rd_req and wr_req are both high. At request, MAR, size and sign_ext are captured; later input changes have no effect.
- Check at request: half needs MAR[0]=0; word needs MAR[1:0]=00; size=11 is illegal. A failed check gives done=err=1 next cycle. No memory access occurs, MDR is unchanged and the FSM stays in IDLE.
- Lane k = MAR[1:0], little-endian. mem_addr = MAR[ADDR_W+1:2].
- States:
  - IDLE: load -> RD_WAIT. Word store -> WR_WAIT. Byte/half store -> RMW_RD.
  - RD_WAIT: mem_en=1, mem_we=0. On mem_ready, MDR <= extracted data and state -> IDLE with done. Byte extract is rdata[8k+7:8k]; half is rdata[16h+15:16h] with h=MAR[1]. Both are extended per sign_ext. Word is passed through.
  - WR_WAIT: mem_en=1, mem_we=1, mem_wdata=MDR. On mem_ready -> IDLE with done.
  - RMW_RD: read as in RD_WAIT. On mem_ready, merge MDR[7:0] into the lane-k byte (or MDR[15:0] into half h), buffer the result and go to RMW_WR. MDR is unchanged.
  - RMW_WR: write the buffered word as in WR_WAIT; then -> IDLE with done.
- Timeout: the wait counter clears on entry to each wait state. If MAX_WAIT cycles pass without mem_ready, the access aborts: done=err=1, state -> IDLE, mem_en=0. MDR and memory are unchanged (an RMW timing out in RMW_WR may have no write).
- Reset asserted mid-access returns all state to reset values immediately. There is no pending completion afterwards.

## Timing
- A request is sampled at edge 0. mem_en is high from cycle 1.
- mem_ready is sampled at each edge while in a wait state.
- Zero-wait load or word store: mem_ready high in cycle 1, done in cycle 2, busy low in cycle 2. Latency = 2 + wait cycles.
- Zero-wait sub-word store: done in cycle 3 (two memory phases).
- Error checks: done/err in cycle 1, busy never high.
- New requests are accepted in the same cycle done is high.
- Timeout with MAX_WAIT=N: done/err in cycle N+1 of the phase.

## Test plan
- Word load at MAR=0x010, mem_rdata=0xDEADBEEF, ready on first wait cycle -> mem_addr=4, MDR=0xDEADBEEF, done at cycle 2, err=0.
- Byte load MAR=0x013, rdata=0x80FF1234, sign_ext=1 -> MDR=0xFFFFFF80. Repeat with sign_ext=0 -> MDR=0x00000080.
- Half store MAR=0x006, MDR=0x0000ABCD, memory word 0x11223344 -> read then write 0xABCD3344 to addr 1, done at cycle 3.
- Word load at MAR=0x002 -> done=err=1 at cycle 1, mem_en never high, MDR unchanged. Same for size=11.
- MAX_WAIT=4, mem_ready held low -> done=err=1 after 4 wait cycles, MDR unchanged. Then drive clr=0 mid-access in a second run -> all outputs 0 asynchronously.
- rd_req and wr_req together, plus MARin=1 while busy -> a load is performed and MAR is unchanged by the busy-time write.
